// File: rtl/rng_log_gen.sv
// Taus88 uniform 32-bit RNG feeding a 3-stage fixed-point natural-log pipeline.
// log_rand_num = ln(r) * 2^27 (unsigned, clamped to MAXLOG); all state advances on enable.
module rng_log_gen #(
    parameter logic [31:0] SEED1     = 32'd12345,
    parameter logic [31:0] SEED2     = 32'd67890,
    parameter logic [31:0] SEED3     = 32'd98765,
    parameter logic [31:0] LN2_CONST = 32'd93032640,
    parameter logic [31:0] MAXLOG    = 32'd2977044471
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic        load_seed,
    input  logic [31:0] seed1,
    input  logic [31:0] seed2,
    input  logic [31:0] seed3,
    input  logic        test_mode,
    input  logic [31:0] test_rand,
    output logic [31:0] rand_out,
    output logic [31:0] log_rand_num,
    output logic        log_valid
);

    // Taus88 generator state
    logic [31:0] s1_q, s2_q, s3_q;
    logic [31:0] s1_d, s2_d, s3_d;
    logic [31:0] s1_step, s2_step, s3_step;
    logic [31:0] b1, b2, b3;

    // Pipeline registers
    logic [31:0] rand_q, rand_d;
    logic [26:0] log2q_q, log2q_d;
    logic [31:0] log_q, log_d;
    logic        v1_q, v2_q, v3_q;

    // Stage-2 / stage-3 datapath
    logic [4:0]  msb_pos;
    logic [31:0] norm;
    logic [21:0] mant;
    logic [53:0] prod;
    logic [31:0] res;
    logic        unused_bits;

    always_comb begin
        b1      = ((s1_q << 13) ^ s1_q) >> 19;
        s1_step = ((s1_q & 32'hFFFF_FFFE) << 12) ^ b1;
        b2      = ((s2_q << 2) ^ s2_q) >> 25;
        s2_step = ((s2_q & 32'hFFFF_FFF8) << 4) ^ b2;
        b3      = ((s3_q << 3) ^ s3_q) >> 11;
        s3_step = ((s3_q & 32'hFFFF_FFF0) << 17) ^ b3;
    end

    // Seeds with too few high bits would lock a component at zero, so they are replaced.
    always_comb begin
        s1_d = s1_q;
        s2_d = s2_q;
        s3_d = s3_q;
        if (load_seed) begin
            s1_d = (seed1[31:1] == 31'd0) ? 32'd2  : seed1;
            s2_d = (seed2[31:3] == 29'd0) ? 32'd8  : seed2;
            s3_d = (seed3[31:4] == 28'd0) ? 32'd16 : seed3;
        end else if (enable) begin
            s1_d = s1_step;
            s2_d = s2_step;
            s3_d = s3_step;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1_q <= SEED1;
            s2_q <= SEED2;
            s3_q <= SEED3;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
            s3_q <= s3_d;
        end
    end

    // Stage 1: uniform sample, taken from the stepped state
    assign rand_d = test_mode ? test_rand : (s1_step ^ s2_step ^ s3_step);

    // Stage 2: log2 in Q5.22 -- integer part is the MSB index, fraction the bits below it
    always_comb begin
        msb_pos = 5'd0;
        for (int i = 1; i < 32; i++) begin
            if (rand_q[i]) begin
                msb_pos = 5'(i);
            end
        end
    end

    assign norm    = rand_q << (5'd31 - msb_pos);
    assign mant    = norm[30:9];
    assign log2q_d = {msb_pos, mant};

    // Stage 3: scale by ln2 back to the natural log
    assign prod  = 54'(log2q_q) * 54'(LN2_CONST);
    assign res   = prod[53:22];
    assign log_d = (res > MAXLOG) ? MAXLOG : res;

    assign unused_bits = ^{norm[31], norm[8:0], prod[21:0]};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rand_q  <= 32'd0;
            log2q_q <= 27'd0;
            log_q   <= 32'd0;
        end else if (enable && !load_seed) begin
            rand_q  <= rand_d;
            log2q_q <= log2q_d;
            log_q   <= log_d;
        end
    end

    // Valid bits track whether each stage holds a post-reset/post-load sample
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
            v3_q <= 1'b0;
        end else if (load_seed) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
            v3_q <= 1'b0;
        end else if (enable) begin
            v1_q <= 1'b1;
            v2_q <= v1_q;
            v3_q <= v2_q;
        end
    end

    assign rand_out     = rand_q;
    assign log_rand_num = log_q;
    assign log_valid    = v3_q;

endmodule

// File: tb/tb_rng_log_gen.sv
// Self-checking bench for rng_log_gen: randomized stimulus, queue scoreboard, and a
// behavioural Taus88 + logarithm reference model.
module tb_rng_log_gen;

    localparam logic [31:0] SEED1  = 32'd12345;
    localparam logic [31:0] SEED2  = 32'd67890;
    localparam logic [31:0] SEED3  = 32'd98765;
    localparam logic [31:0] MAXLOG = 32'd2977044471;
    localparam longint unsigned LN2 = 64'd93032640;
    localparam real SCALE = 134217728.0;

    typedef struct {
        logic [31:0] r;
        logic [31:0] exp;
    } entry_t;

    logic        clock;
    logic        reset;
    logic        enable;
    logic        load_seed;
    logic [31:0] seed1, seed2, seed3;
    logic        test_mode;
    logic [31:0] test_rand;
    logic [31:0] rand_out;
    logic [31:0] log_rand_num;
    logic        log_valid;

    int n_total;
    int n_pass;

    // Reference generator state and scoreboard queues
    logic [31:0] m1, m2, m3;
    logic [31:0] rnd_q[$];
    entry_t      log_q[$];

    // Monitor state
    logic        en_s, ld_s, rst_s, exp_valid;
    int          cnt;
    logic [31:0] last_rand, last_log;
    bit          log_known, fresh;
    entry_t      e_mon;
    real         ideal, err;

    rng_log_gen dut (
        .clock        (clock),
        .reset        (reset),
        .enable       (enable),
        .load_seed    (load_seed),
        .seed1        (seed1),
        .seed2        (seed2),
        .seed3        (seed3),
        .test_mode    (test_mode),
        .test_rand    (test_rand),
        .rand_out     (rand_out),
        .log_rand_num (log_rand_num),
        .log_valid    (log_valid)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input longint unsigned act,
                         input longint unsigned exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    endtask

    task automatic fail_now(input string name);
        n_total++;
        $display("FAIL %s: scoreboard queue empty at %0t", name, $time);
    endtask

    // Taus88 as in L'Ecuyer's C reference
    task automatic taus_step();
        logic [31:0] b;
        b  = ((m1 << 13) ^ m1) >> 19;
        m1 = ((m1 & 32'hFFFF_FFFE) << 12) ^ b;
        b  = ((m2 << 2) ^ m2) >> 25;
        m2 = ((m2 & 32'hFFFF_FFF8) << 4) ^ b;
        b  = ((m3 << 3) ^ m3) >> 11;
        m3 = ((m3 & 32'hFFFF_FFF0) << 17) ^ b;
    endtask

    // floor(log2 r) plus truncated linear fraction (r - 2^p)/2^p in 22 bits, times ln2
    function automatic logic [31:0] log_model(input logic [31:0] r);
        longint unsigned p, frac, l2, res;
        p = 0;
        while (p < 31 && (64'(r) >> (p + 1)) != 64'd0) p++;
        if (r == 32'd0) frac = 64'd0;
        else frac = ((64'(r) - (64'd1 << p)) << 22) >> p;
        l2  = (p << 22) + frac;
        res = (l2 * LN2) >> 22;
        if (res > 64'(MAXLOG)) res = 64'(MAXLOG);
        return res[31:0];
    endfunction

    task automatic drive(input logic en, input logic ld, input logic tm, input logic [31:0] tr);
        entry_t      e;
        logic [31:0] r;
        @(negedge clock);
        enable    = en;
        load_seed = ld;
        test_mode = tm;
        test_rand = tr;
        if (ld) begin
            m1 = (seed1 < 32'd2)  ? 32'd2  : seed1;
            m2 = (seed2 < 32'd8)  ? 32'd8  : seed2;
            m3 = (seed3 < 32'd16) ? 32'd16 : seed3;
            log_q.delete();
            rnd_q.delete();
        end else if (en) begin
            taus_step();
            r = tm ? tr : (m1 ^ m2 ^ m3);
            rnd_q.push_back(r);
            e.r   = r;
            e.exp = log_model(r);
            log_q.push_back(e);
        end
    endtask

    // Monitor: samples 1 time unit after each rising edge
    initial begin : monitor
        forever begin
            @(posedge clock);
            en_s  = enable;
            ld_s  = load_seed;
            rst_s = reset;
            #1;
            if (rst_s) begin
                cnt       = 0;
                last_rand = 32'd0;
                last_log  = 32'd0;
                log_known = 1'b1;
                fresh     = 1'b1;
                check("reset_rand_out", rand_out, 0);
                check("reset_log", log_rand_num, 0);
                check("reset_valid", log_valid, 0);
            end else begin
                if (ld_s) begin
                    cnt   = 0;
                    fresh = 1'b0;
                end else if (en_s && cnt < 3) begin
                    cnt++;
                end
                exp_valid = (cnt >= 3);
                check("log_valid", log_valid, exp_valid);
                if (en_s && !ld_s) begin
                    if (rnd_q.size() == 0) fail_now("rand_out");
                    else begin
                        last_rand = rnd_q.pop_front();
                        check("rand_out", rand_out, last_rand);
                    end
                    if (exp_valid) begin
                        if (log_q.size() == 0) fail_now("log_rand_num");
                        else begin
                            e_mon = log_q.pop_front();
                            check("log_rand_num", log_rand_num, e_mon.exp);
                            last_log  = e_mon.exp;
                            log_known = 1'b1;
                            n_total++;
                            if (log_rand_num <= MAXLOG) n_pass++;
                            else $display("FAIL log_ceiling: got %0d, limit %0d", log_rand_num,
                                          MAXLOG);
                            if (e_mon.r != 32'd0) begin
                                ideal = $ln(real'(e_mon.r)) * SCALE;
                                err   = real'(log_rand_num) - ideal;
                                if (err < 0.0) err = -err;
                                n_total++;
                                if (err < 0.09 * SCALE) n_pass++;
                                else $display("FAIL log_accuracy: got %0d, ideal %0.1f (r=%0h)",
                                              log_rand_num, ideal, e_mon.r);
                            end
                        end
                    end else if (!fresh) begin
                        // stale pre-load data is still draining through the pipeline
                        log_known = 1'b0;
                    end
                end else begin
                    check("rand_hold", rand_out, last_rand);
                end
                if (log_known && !(en_s && !ld_s && exp_valid))
                    check("log_hold", log_rand_num, last_log);
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        n_total   = 0;
        n_pass    = 0;
        reset     = 1'b1;
        enable    = 1'b0;
        load_seed = 1'b0;
        test_mode = 1'b0;
        test_rand = 32'd0;
        seed1     = 32'd0;
        seed2     = 32'd0;
        seed3     = 32'd0;
        m1 = SEED1;
        m2 = SEED2;
        m3 = SEED3;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;

        // Directed log values including r=0, r=1 and the all-ones ceiling case
        drive(1'b1, 1'b0, 1'b1, 32'd1);
        drive(1'b1, 1'b0, 1'b1, 32'd2);
        drive(1'b1, 1'b0, 1'b1, 32'd3);
        drive(1'b1, 1'b0, 1'b1, 32'h8000_0000);
        drive(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF);
        drive(1'b1, 1'b0, 1'b1, 32'd0);

        repeat (40) drive(1'b1, 1'b0, 1'b0, $urandom);
        repeat (5) drive(1'b0, 1'b0, 1'b0, $urandom);
        repeat (40) drive(1'b1, 1'b0, 1'b0, $urandom);

        // Zero-lock guarded seed load, then a load while stalled
        seed1 = 32'd0;
        seed2 = 32'd5;
        seed3 = 32'd7;
        drive(1'b1, 1'b1, 1'b0, 32'd0);
        repeat (20) drive(1'b1, 1'b0, 1'b0, 32'd0);
        seed1 = $urandom;
        seed2 = $urandom;
        seed3 = $urandom;
        drive(1'b0, 1'b1, 1'b0, 32'd0);
        repeat (3) drive(1'b0, 1'b0, 1'b0, 32'd0);
        repeat (20) drive(1'b1, 1'b0, 1'b0, 32'd0);

        // Asynchronous reset between edges with a valid output present
        #2;
        check("pre_reset_valid", log_valid, 1);
        reset = 1'b1;
        #1;
        check("async_reset_valid", log_valid, 0);
        check("async_reset_log", log_rand_num, 0);
        check("async_reset_rand", rand_out, 0);
        log_q.delete();
        rnd_q.delete();
        m1 = SEED1;
        m2 = SEED2;
        m3 = SEED3;
        @(negedge clock);
        reset  = 1'b0;
        enable = 1'b0;

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(99) == 0) begin
                seed1 = $urandom_range(3);
                seed2 = $urandom_range(15);
                seed3 = $urandom;
                drive(1'($urandom_range(1)), 1'b1, 1'b0, 32'd0);
            end else begin
                drive($urandom_range(4) != 0, 1'b0, $urandom_range(9) == 0,
                      ($urandom_range(7) == 0) ? 32'hFFFF_FFFF : $urandom);
            end
        end
        drive(1'b0, 1'b0, 1'b0, 32'd0);
        drive(1'b0, 1'b0, 1'b0, 32'd0);
        @(posedge clock);
        #2;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
